// File: rtl/dca_xmi_lpi_arbiter.sv
// N-port LPI-to-XMI request/response arbiter with fixed-priority or round-robin
// grant, burst locking, tag-routed responses and an outstanding-transaction cap.
module dca_xmi_lpi_arbiter #(
   parameter int NUM_PORT        = 4,
   parameter int BW_ADDR         = 32,
   parameter int BW_DATA         = 32,
   parameter int BW_BURDEN       = 1,
   parameter int MAX_OUTSTANDING = 8,
   parameter int ARB_MODE        = 1,
   localparam int BW_PID         = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
   input  logic                            clk,
   input  logic                            clear,
   output logic                            busy,

   input  logic [NUM_PORT-1:0]             port_qvalid,
   output logic [NUM_PORT-1:0]             port_qready,
   input  logic [NUM_PORT-1:0]             port_qlast,
   input  logic [NUM_PORT-1:0]             port_qwrite,
   input  logic [NUM_PORT*8-1:0]           port_qlen,
   input  logic [NUM_PORT*3-1:0]           port_qsize,
   input  logic [NUM_PORT*2-1:0]           port_qburst,
   input  logic [NUM_PORT*BW_DATA/8-1:0]   port_qwstrb,
   input  logic [NUM_PORT*BW_DATA-1:0]     port_qwdata,
   input  logic [NUM_PORT*BW_ADDR-1:0]     port_qaddr,
   input  logic [NUM_PORT*BW_BURDEN-1:0]   port_qburden,

   output logic [NUM_PORT-1:0]             port_yvalid,
   input  logic [NUM_PORT-1:0]             port_yready,
   output logic                            port_ylast,
   output logic                            port_ywreply,
   output logic [1:0]                      port_yresp,
   output logic [BW_DATA-1:0]              port_yrdata,
   output logic [BW_BURDEN-1:0]            port_yburden,

   output logic                            slxqvalid,
   input  logic                            slxqready,
   output logic                            slxqlast,
   output logic                            slxqwrite,
   output logic [7:0]                      slxqlen,
   output logic [2:0]                      slxqsize,
   output logic [1:0]                      slxqburst,
   output logic [BW_DATA/8-1:0]            slxqwstrb,
   output logic [BW_DATA-1:0]              slxqwdata,
   output logic [BW_ADDR-1:0]              slxqaddr,
   output logic [BW_PID+BW_BURDEN-1:0]     slxqburden,

   input  logic                            slxyvalid,
   output logic                            slxyready,
   input  logic                            slxylast,
   input  logic                            slxywreply,
   input  logic [1:0]                      slxyresp,
   input  logic [BW_DATA-1:0]              slxyrdata,
   input  logic [BW_PID+BW_BURDEN-1:0]     slxyburden,
   output logic                            tag_error
);

   localparam int BW_STRB = BW_DATA / 8;

   logic              lock_q, lock_d;
   logic [BW_PID-1:0] grant_id_q, grant_id_d;
   logic [BW_PID-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]        out_cnt_q, out_cnt_d;

   logic [BW_PID-1:0] winner;
   logic [BW_PID-1:0] cand;
   logic              winner_found;
   logic              cap_reached;
   logic              q_hs;
   logic              y_hs;
   logic              cnt_inc;
   logic              cnt_dec;
   logic [BW_PID-1:0] tag;
   logic              tag_ok;

   // A held lock pins the grant; otherwise pick this cycle's winner combinationally.
   always_comb begin
      winner       = '0;
      cand         = '0;
      winner_found = 1'b0;
      if (lock_q) begin
         winner       = grant_id_q;
         winner_found = port_qvalid[grant_id_q];
      end else if (ARB_MODE == 1) begin
         for (int k = NUM_PORT - 1; k >= 0; k--) begin
            cand = BW_PID'((int'(rr_ptr_q) + k) % NUM_PORT);
            if (port_qvalid[cand]) begin
               winner       = cand;
               winner_found = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_PORT - 1; k >= 0; k--) begin
            cand = BW_PID'(k);
            if (port_qvalid[cand]) begin
               winner       = cand;
               winner_found = 1'b1;
            end
         end
      end
   end

   // The cap only stops new grants; a burst already locked runs to its last beat.
   assign cap_reached = (out_cnt_q == 8'(MAX_OUTSTANDING)) && !lock_q;

   always_comb begin
      slxqvalid   = !clear && winner_found && !cap_reached;
      port_qready = '0;
      if (slxqvalid) begin
         port_qready[winner] = slxqready;
      end
      slxqlast   = port_qlast[winner];
      slxqwrite  = port_qwrite[winner];
      slxqlen    = port_qlen[int'(winner)*8 +: 8];
      slxqsize   = port_qsize[int'(winner)*3 +: 3];
      slxqburst  = port_qburst[int'(winner)*2 +: 2];
      slxqwstrb  = port_qwstrb[int'(winner)*BW_STRB +: BW_STRB];
      slxqwdata  = port_qwdata[int'(winner)*BW_DATA +: BW_DATA];
      slxqaddr   = port_qaddr[int'(winner)*BW_ADDR +: BW_ADDR];
      slxqburden = {winner, port_qburden[int'(winner)*BW_BURDEN +: BW_BURDEN]};
   end

   // Responses are steered by the port tag; unknown tags are sunk and flagged.
   assign tag    = slxyburden[BW_PID+BW_BURDEN-1 -: BW_PID];
   assign tag_ok = int'(tag) < NUM_PORT;

   always_comb begin
      port_yvalid = '0;
      slxyready   = 1'b0;
      tag_error   = 1'b0;
      if (!clear) begin
         if (tag_ok) begin
            port_yvalid[tag] = slxyvalid;
            slxyready        = port_yready[tag];
         end else begin
            slxyready = 1'b1;
            tag_error = slxyvalid;
         end
      end
   end

   assign port_ylast   = slxylast;
   assign port_ywreply = slxywreply;
   assign port_yresp   = slxyresp;
   assign port_yrdata  = slxyrdata;
   assign port_yburden = slxyburden[BW_BURDEN-1:0];

   assign q_hs    = slxqvalid && slxqready;
   assign y_hs    = slxyvalid && slxyready;
   assign cnt_inc = q_hs && slxqlast;
   assign cnt_dec = y_hs && slxylast && (out_cnt_q != 8'd0);

   always_comb begin
      lock_d     = lock_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      out_cnt_d  = out_cnt_q;
      if (q_hs) begin
         if (slxqlast) begin
            lock_d = 1'b0;
            if (ARB_MODE == 1) begin
               rr_ptr_d = (int'(winner) == NUM_PORT - 1) ? '0 : winner + 1'b1;
            end
         end else begin
            lock_d     = 1'b1;
            grant_id_d = winner;
         end
      end
      if (cnt_inc && !cnt_dec) begin
         out_cnt_d = out_cnt_q + 8'd1;
      end else if (cnt_dec && !cnt_inc) begin
         out_cnt_d = out_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         lock_q     <= 1'b0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         out_cnt_q  <= 8'd0;
      end else begin
         lock_q     <= lock_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   assign busy = lock_q || (out_cnt_q != 8'd0);

endmodule

// File: tb/tb_dca_xmi_lpi_arbiter.sv
// Directed bench: instance a is 4-port round robin, instance b is 3-port
// fixed priority with a two-transaction cap (exercises tag 3 as out of range).
module tb_dca_xmi_lpi_arbiter;

   logic clk = 1'b0;
   logic clear;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic         a_busy;
   logic [3:0]   a_port_qvalid, a_port_qready, a_port_qlast, a_port_qwrite;
   logic [31:0]  a_port_qlen;
   logic [11:0]  a_port_qsize;
   logic [7:0]   a_port_qburst;
   logic [15:0]  a_port_qwstrb;
   logic [127:0] a_port_qwdata, a_port_qaddr;
   logic [3:0]   a_port_qburden;
   logic [3:0]   a_port_yvalid, a_port_yready;
   logic         a_port_ylast, a_port_ywreply, a_port_yburden;
   logic [1:0]   a_port_yresp;
   logic [31:0]  a_port_yrdata;
   logic         a_slxqvalid, a_slxqready, a_slxqlast, a_slxqwrite;
   logic [7:0]   a_slxqlen;
   logic [2:0]   a_slxqsize;
   logic [1:0]   a_slxqburst;
   logic [3:0]   a_slxqwstrb;
   logic [31:0]  a_slxqwdata, a_slxqaddr;
   logic [2:0]   a_slxqburden;
   logic         a_slxyvalid, a_slxyready, a_slxylast, a_slxywreply;
   logic [1:0]   a_slxyresp;
   logic [31:0]  a_slxyrdata;
   logic [2:0]   a_slxyburden;
   logic         a_tag_error;

   logic         b_busy;
   logic [2:0]   b_port_qvalid, b_port_qready, b_port_qlast, b_port_qwrite;
   logic [23:0]  b_port_qlen;
   logic [8:0]   b_port_qsize;
   logic [5:0]   b_port_qburst;
   logic [11:0]  b_port_qwstrb;
   logic [95:0]  b_port_qwdata, b_port_qaddr;
   logic [2:0]   b_port_qburden;
   logic [2:0]   b_port_yvalid, b_port_yready;
   logic         b_port_ylast, b_port_ywreply, b_port_yburden;
   logic [1:0]   b_port_yresp;
   logic [31:0]  b_port_yrdata;
   logic         b_slxqvalid, b_slxqready, b_slxqlast, b_slxqwrite;
   logic [7:0]   b_slxqlen;
   logic [2:0]   b_slxqsize;
   logic [1:0]   b_slxqburst;
   logic [3:0]   b_slxqwstrb;
   logic [31:0]  b_slxqwdata, b_slxqaddr;
   logic [2:0]   b_slxqburden;
   logic         b_slxyvalid, b_slxyready, b_slxylast, b_slxywreply;
   logic [1:0]   b_slxyresp;
   logic [31:0]  b_slxyrdata;
   logic [2:0]   b_slxyburden;
   logic         b_tag_error;

   dca_xmi_lpi_arbiter #(
      .NUM_PORT(4), .BW_ADDR(32), .BW_DATA(32), .BW_BURDEN(1),
      .MAX_OUTSTANDING(8), .ARB_MODE(1)
   ) dut_a (
      .clk(clk), .clear(clear), .busy(a_busy),
      .port_qvalid(a_port_qvalid), .port_qready(a_port_qready), .port_qlast(a_port_qlast),
      .port_qwrite(a_port_qwrite), .port_qlen(a_port_qlen), .port_qsize(a_port_qsize),
      .port_qburst(a_port_qburst), .port_qwstrb(a_port_qwstrb), .port_qwdata(a_port_qwdata),
      .port_qaddr(a_port_qaddr), .port_qburden(a_port_qburden),
      .port_yvalid(a_port_yvalid), .port_yready(a_port_yready), .port_ylast(a_port_ylast),
      .port_ywreply(a_port_ywreply), .port_yresp(a_port_yresp), .port_yrdata(a_port_yrdata),
      .port_yburden(a_port_yburden),
      .slxqvalid(a_slxqvalid), .slxqready(a_slxqready), .slxqlast(a_slxqlast),
      .slxqwrite(a_slxqwrite), .slxqlen(a_slxqlen), .slxqsize(a_slxqsize),
      .slxqburst(a_slxqburst), .slxqwstrb(a_slxqwstrb), .slxqwdata(a_slxqwdata),
      .slxqaddr(a_slxqaddr), .slxqburden(a_slxqburden),
      .slxyvalid(a_slxyvalid), .slxyready(a_slxyready), .slxylast(a_slxylast),
      .slxywreply(a_slxywreply), .slxyresp(a_slxyresp), .slxyrdata(a_slxyrdata),
      .slxyburden(a_slxyburden), .tag_error(a_tag_error)
   );

   dca_xmi_lpi_arbiter #(
      .NUM_PORT(3), .BW_ADDR(32), .BW_DATA(32), .BW_BURDEN(1),
      .MAX_OUTSTANDING(2), .ARB_MODE(0)
   ) dut_b (
      .clk(clk), .clear(clear), .busy(b_busy),
      .port_qvalid(b_port_qvalid), .port_qready(b_port_qready), .port_qlast(b_port_qlast),
      .port_qwrite(b_port_qwrite), .port_qlen(b_port_qlen), .port_qsize(b_port_qsize),
      .port_qburst(b_port_qburst), .port_qwstrb(b_port_qwstrb), .port_qwdata(b_port_qwdata),
      .port_qaddr(b_port_qaddr), .port_qburden(b_port_qburden),
      .port_yvalid(b_port_yvalid), .port_yready(b_port_yready), .port_ylast(b_port_ylast),
      .port_ywreply(b_port_ywreply), .port_yresp(b_port_yresp), .port_yrdata(b_port_yrdata),
      .port_yburden(b_port_yburden),
      .slxqvalid(b_slxqvalid), .slxqready(b_slxqready), .slxqlast(b_slxqlast),
      .slxqwrite(b_slxqwrite), .slxqlen(b_slxqlen), .slxqsize(b_slxqsize),
      .slxqburst(b_slxqburst), .slxqwstrb(b_slxqwstrb), .slxqwdata(b_slxqwdata),
      .slxqaddr(b_slxqaddr), .slxqburden(b_slxqburden),
      .slxyvalid(b_slxyvalid), .slxyready(b_slxyready), .slxylast(b_slxylast),
      .slxywreply(b_slxywreply), .slxyresp(b_slxyresp), .slxyrdata(b_slxyrdata),
      .slxyburden(b_slxyburden), .tag_error(b_tag_error)
   );

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear          = 1'b1;
      a_port_qvalid  = 4'b1111;
      a_port_qlast   = 4'b1111;
      a_port_qwrite  = 4'b0000;
      a_port_qlen    = '0;
      a_port_qsize   = '0;
      a_port_qburst  = '0;
      a_port_qwstrb  = '1;
      a_port_qburden = 4'b1010;
      for (int p = 0; p < 4; p++) begin
         a_port_qaddr[p*32 +: 32]  = 32'h1000 + 32'(p) * 32'h100;
         a_port_qwdata[p*32 +: 32] = 32'hA0A0_0000 + 32'(p);
      end
      a_port_yready  = 4'b1111;
      a_slxqready    = 1'b1;
      a_slxyvalid    = 1'b1;
      a_slxylast     = 1'b1;
      a_slxywreply   = 1'b0;
      a_slxyresp     = 2'b00;
      a_slxyrdata    = '0;
      a_slxyburden   = {2'd1, 1'b0};

      b_port_qvalid  = 3'b000;
      b_port_qlast   = 3'b111;
      b_port_qwrite  = 3'b000;
      b_port_qlen    = '0;
      b_port_qsize   = '0;
      b_port_qburst  = '0;
      b_port_qwstrb  = '1;
      b_port_qwdata  = '0;
      b_port_qaddr   = '0;
      b_port_qburden = 3'b000;
      b_port_yready  = 3'b000;
      b_slxqready    = 1'b0;
      b_slxyvalid    = 1'b1;
      b_slxylast     = 1'b1;
      b_slxywreply   = 1'b0;
      b_slxyresp     = 2'b00;
      b_slxyrdata    = '0;
      b_slxyburden   = {2'd3, 1'b0};

      // Outputs forced quiet while clear is held.
      next_cycle();
      check_output("clr_a_qready", 64'(a_port_qready), 64'h0);
      check_output("clr_a_slxqvalid", 64'(a_slxqvalid), 64'h0);
      check_output("clr_a_slxyready", 64'(a_slxyready), 64'h0);
      check_output("clr_a_yvalid", 64'(a_port_yvalid), 64'h0);
      check_output("clr_b_tag_error", 64'(b_tag_error), 64'h0);
      check_output("clr_b_slxyready", 64'(b_slxyready), 64'h0);

      next_cycle();
      clear         = 1'b0;
      a_port_qvalid = 4'b0000;
      a_slxyvalid   = 1'b0;
      b_slxyvalid   = 1'b0;
      #1;
      check_output("idle_a_busy", 64'(a_busy), 64'h0);
      check_output("idle_b_busy", 64'(b_busy), 64'h0);

      // b: fixed priority, ports 1 and 2 valid -> port 1 always.
      b_port_qvalid = 3'b110;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check_output("b_fp_valid", 64'(b_slxqvalid), 64'h1);
         check_output("b_fp_tag", 64'(b_slxqburden[2:1]), 64'h1);
      end
      b_slxqready = 1'b1;
      #1;
      check_output("b_fp_qready", 64'(b_port_qready), 64'h2);
      next_cycle();

      // b: cap of two outstanding blocks the next grant.
      b_port_qvalid = 3'b001;
      #1;
      check_output("b_cap_second", 64'(b_port_qready), 64'h1);
      next_cycle();
      check_output("b_cap_blocked", 64'(b_slxqvalid), 64'h0);
      check_output("b_cap_qready", 64'(b_port_qready), 64'h0);
      check_output("b_cap_busy", 64'(b_busy), 64'h1);
      next_cycle();
      b_slxyvalid   = 1'b1;
      b_slxyburden  = {2'd0, 1'b1};
      b_port_yready = 3'b001;
      b_slxyrdata   = 32'h1234_5678;
      #1;
      check_output("b_resp_still_blk", 64'(b_slxqvalid), 64'h0);
      check_output("b_resp_slxyready", 64'(b_slxyready), 64'h1);
      check_output("b_resp_yvalid", 64'(b_port_yvalid), 64'h1);
      check_output("b_resp_rdata", 64'(b_port_yrdata), 64'h1234_5678);
      check_output("b_resp_yburden", 64'(b_port_yburden), 64'h1);
      next_cycle();
      b_slxyvalid = 1'b0;
      #1;
      check_output("b_third_issue", 64'(b_port_qready), 64'h1);
      next_cycle();
      check_output("b_cap_again", 64'(b_slxqvalid), 64'h0);

      // b: out-of-range tag is sunk, flagged and still retires a transaction.
      b_slxyvalid   = 1'b1;
      b_slxyburden  = {2'd3, 1'b0};
      b_port_yready = 3'b000;
      #1;
      check_output("b_tag3_slxyready", 64'(b_slxyready), 64'h1);
      check_output("b_tag3_error", 64'(b_tag_error), 64'h1);
      check_output("b_tag3_yvalid", 64'(b_port_yvalid), 64'h0);
      next_cycle();
      b_slxyvalid = 1'b0;
      b_slxqready = 1'b0;
      #1;
      check_output("b_tag3_pulse_end", 64'(b_tag_error), 64'h0);
      check_output("b_tag3_retired", 64'(b_slxqvalid), 64'h1);
      b_port_qvalid = 3'b000;

      // b: drain to zero, then a response at zero is forwarded but not counted.
      b_slxyvalid   = 1'b1;
      b_slxyburden  = {2'd2, 1'b0};
      b_port_yready = 3'b100;
      next_cycle();
      check_output("b_zero_yvalid", 64'(b_port_yvalid), 64'h4);
      check_output("b_zero_slxyready", 64'(b_slxyready), 64'h1);
      check_output("b_zero_busy_pre", 64'(b_busy), 64'h0);
      next_cycle();
      b_slxyvalid = 1'b0;
      #1;
      check_output("b_zero_no_wrap", 64'(b_busy), 64'h0);

      // a: round robin over four single-beat reads.
      a_port_qvalid = 4'b1111;
      a_port_qlast  = 4'b1111;
      a_slxqready   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_output("a_rr_qready", 64'(a_port_qready), 64'(4'b0001 << (i % 4)));
         check_output("a_rr_burden", 64'(a_slxqburden),
                      64'({2'(i % 4), a_port_qburden[i % 4]}));
         check_output("a_rr_addr", 64'(a_slxqaddr), 64'(32'h1000 + 32'(i % 4) * 32'h100));
         next_cycle();
      end

      // a: port 2 locks a 4-beat write while port 2 also receives a stalled response.
      a_port_qvalid = 4'b0101;
      a_port_qlast  = 4'b0001;
      a_port_qwrite = 4'b0100;
      a_slxyvalid   = 1'b1;
      a_slxyburden  = {2'd2, 1'b1};
      a_slxyrdata   = 32'hDEAD_BEEF;
      a_port_yready = 4'b1011;
      for (int beat = 0; beat < 4; beat++) begin
         if (beat == 3) begin
            a_port_qlast  = 4'b0101;
            a_port_yready = 4'b1111;
         end
         #1;
         check_output("a_lock_qready", 64'(a_port_qready), 64'h4);
         check_output("a_lock_wdata", 64'(a_slxqwdata), 64'hA0A0_0002);
         check_output("a_lock_qlast", 64'(a_slxqlast), 64'(beat == 3));
         check_output("a_resp_slxyready", 64'(a_slxyready), 64'(beat == 3));
         check_output("a_resp_yvalid", 64'(a_port_yvalid), 64'h4);
         check_output("a_resp_rdata", 64'(a_port_yrdata), 64'hDEAD_BEEF);
         next_cycle();
      end
      a_slxyvalid   = 1'b0;
      a_port_qvalid = 4'b0001;
      a_port_qlast  = 4'b0001;
      a_port_qwrite = 4'b0000;
      #1;
      check_output("a_after_lock", 64'(a_port_qready), 64'h1);
      next_cycle();

      // a: start a burst on port 1, then clear mid-burst.
      a_port_qvalid = 4'b0010;
      a_port_qlast  = 4'b0000;
      #1;
      check_output("a_burst_start", 64'(a_port_qready), 64'h2);
      next_cycle();
      check_output("a_burst_busy", 64'(a_busy), 64'h1);
      clear         = 1'b1;
      a_port_qvalid = 4'b1111;
      a_slxyvalid   = 1'b1;
      a_slxyburden  = {2'd1, 1'b0};
      #1;
      check_output("a_clr_qready", 64'(a_port_qready), 64'h0);
      check_output("a_clr_slxqvalid", 64'(a_slxqvalid), 64'h0);
      check_output("a_clr_slxyready", 64'(a_slxyready), 64'h0);
      check_output("a_clr_yvalid", 64'(a_port_yvalid), 64'h0);
      next_cycle();
      clear        = 1'b0;
      a_slxyvalid  = 1'b0;
      a_port_qlast = 4'b1111;
      a_slxqready  = 1'b0;
      #1;
      check_output("a_post_clr_busy", 64'(a_busy), 64'h0);
      check_output("a_post_clr_tag", 64'(a_slxqburden[2:1]), 64'h0);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dca_xmi_lpi_arbiter.md
Name: dca_xmi_lpi_arbiter

Overview:
- N-port request/response arbiter that merges several LSU-side LPI master channels onto one XMI port.
- Generalises the static read/write two-way select into a parametrised arbiter with NUM_PORT channels, fixed-priority or round-robin grant, and burst locking.
- Responses are routed back by a port tag carried in the XMI burden field, and a counter caps outstanding transactions.
- Sits between multiple DCA matrix LSUs (or one LSU's read/write engines) and the shared memory interface.

Parameters:
NUM_PORT, 4, number of requesting channels (2..16)
BW_ADDR, 32, address width
BW_DATA, 32, data width
BW_BURDEN, 1, user burden width per port
MAX_OUTSTANDING, 8, max accepted-but-unanswered transactions (1..255)
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin
BW_PID (local), clog2(NUM_PORT) min 1, port tag width

Ports:
clk  in  1  clock
clear  in  1  synchronous active-high reset
busy  out  1  lock held or outstanding count nonzero
port_qvalid  in  NUM_PORT  per-port request valid
port_qready  out  NUM_PORT  per-port request accept
port_qlast  in  NUM_PORT  last beat of request
port_qwrite  in  NUM_PORT  write request
port_qlen  in  NUM_PORT*8  burst length
port_qsize  in  NUM_PORT*3  beat size
port_qburst  in  NUM_PORT*2  burst type
port_qwstrb  in  NUM_PORT*BW_DATA/8  write strobe
port_qwdata  in  NUM_PORT*BW_DATA  write data
port_qaddr  in  NUM_PORT*BW_ADDR  address
port_qburden  in  NUM_PORT*BW_BURDEN  user burden
port_yvalid  out  NUM_PORT  per-port response valid
port_yready  in  NUM_PORT  per-port response accept
port_ylast  out  1  broadcast response last
port_ywreply  out  1  broadcast write-reply flag
port_yresp  out  2  broadcast response code
port_yrdata  out  BW_DATA  broadcast read data
port_yburden  out  BW_BURDEN  stripped user burden
slxqvalid, slxqready, slxqlast, slxqwrite, slxqlen, slxqsize, slxqburst, slxqwstrb, slxqwdata, slxqaddr  out/in/out...  XMI request fields
slxqburden  out  BW_PID+BW_BURDEN  {port tag, user burden}
slxyvalid, slxyready, slxylast, slxywreply, slxyresp, slxyrdata  in/out/in...  XMI response fields
slxyburden  in  BW_PID+BW_BURDEN  returned tag and burden
tag_error  out  1  one-cycle pulse when a response carries tag >= NUM_PORT

Behaviour:
- State: lock (1b), grant_id (BW_PID), rr_ptr (BW_PID), out_cnt (8b). All are 0 in the cycle after clear.
- While clear=1, all of the following are forced to 0: port_qready, slxqvalid, slxyready, port_yvalid, tag_error.
- Request path states:
  - UNLOCKED: the winner is chosen combinationally the same cycle.
    - ARB_MODE=1 uses the first valid port at or after rr_ptr (cyclic).
    - ARB_MODE=0 uses the lowest valid index.
  - LOCKED: the winner is grant_id only. Other ports' qready=0.
- No grant (slxqvalid=0) when out_cnt==MAX_OUTSTANDING. A locked burst continues regardless.
- The winner's fields pass straight to slxq*, with slxqburden={winner,burden}. port_qready[winner]=slxqready. Zero latency.
- Handshake without last: lock<=1, grant_id<=winner.
- Handshake with last: lock<=0, out_cnt+1. If ARB_MODE=1, rr_ptr<=winner+1, wrapping to 0 past NUM_PORT-1.
- Response path:
  - tag = slxyburden[MSB -: BW_PID].
  - port_yvalid[tag]=slxyvalid and slxyready=port_yready[tag].
  - Data fields are broadcast. port_yburden is the low BW_BURDEN bits.
- Response handshake with slxylast: out_cnt-1.
- Simultaneous increment and decrement in one cycle leaves out_cnt unchanged.
- out_cnt never wraps. A decrement at 0 is ignored, and a response arriving then is still forwarded.
- Tag >= NUM_PORT: slxyready=1 (sink), no port_yvalid, tag_error pulses per beat, and the beat still counts for the last-decrement.
- Request and response paths are independent. A port may receive a response while another port holds the lock.
- busy = lock | (out_cnt!=0).

Test Plan:
- NUM_PORT=4, ARB_MODE=1, ports 0..3 all valid with single-beat reads, slxqready=1 -> grants in order 0,1,2,3,0; rr_ptr=1 after the first grant.
- ARB_MODE=0, ports 1 and 3 continuously valid -> port 1 granted every cycle, port 3 never; switching to ARB_MODE=1 alternates 1,3.
- Port 2 sends a 4-beat write with qlast on beat 4, port 0 valid throughout -> port 0 qready=0 until beat 4 accepted; port 0 granted on the next cycle.
- MAX_OUTSTANDING=2, three reads with no responses -> third blocked (slxqvalid=0); one response with last -> third issues the next cycle, out_cnt returns to 2.
- Response with slxyburden tag=2, port_yready[2]=0 for 3 cycles -> slxyready=0 for 3 cycles and data held; on accept, out_cnt decrements by 1. NUM_PORT=3 with tag=3 -> slxyready=1, tag_error=1, no port_yvalid.
- clear asserted mid-burst with lock=1, out_cnt=5 -> next cycle lock=0, out_cnt=0, rr_ptr=0, busy=0; all readies are 0 during clear.
